enc_pos_ctrl_core: RTL

Slot-interface controller for a PMOD rotary encoder (JA = {SW, BTN, B, A}). It synchronizes and filters A/B, then sequences a quadrature-decode FSM. Each decoded step updates a bounded signed position counter, with wrap or saturate policy. It also latches button/error events for software polling over the standard 5-bit-address / 32-bit-data slot bus.

---
 rtl/enc_pos_ctrl_core.sv | 341 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/enc_pos_ctrl_core.sv
// ---------------------------------------------------------------------------
// enc_pos_ctrl_core
// Slot-bus controller for a PMOD rotary encoder (JA = {SW, BTN, B, A}).
// Synchronizes and debounces A/B, decodes quadrature with a four-state FSM,
// keeps a bounded signed position (wrap or saturate), and latches button and
// decode-error events for software polling.
//
// Optional build macro: ENC_IRQ_EN
//   defined   -> adds output 'irq' and register 5 IRQ_MASK
//   undefined -> no irq port, address 5 reads 0 and ignores writes
// ---------------------------------------------------------------------------
module enc_pos_ctrl_core #(
    parameter int W    = 16,  // position/limit width (2..31)
    parameter int FILT = 8    // stable samples needed to accept new A/B (1..255)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
`ifdef ENC_IRQ_EN
    output logic        irq,
`endif
    input  logic [3:0]  JA
);

    // -----------------------------------------------------------------------
    // Register map
    // -----------------------------------------------------------------------
    localparam logic [4:0] ADDR_POS    = 5'd0;
    localparam logic [4:0] ADDR_CTRL   = 5'd1;
    localparam logic [4:0] ADDR_MIN    = 5'd2;
    localparam logic [4:0] ADDR_MAX    = 5'd3;
    localparam logic [4:0] ADDR_STATUS = 5'd4;
`ifdef ENC_IRQ_EN
    localparam logic [4:0] ADDR_IRQM   = 5'd5;
`endif

    localparam logic [7:0]          FILT_C    = 8'(FILT);
    localparam logic signed [W-1:0] MIN_RESET = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_RESET = {1'b0, {(W-1){1'b1}}};

    // Quadrature states are encoded directly as the filtered {B,A} value.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } qstate_e;

    // -----------------------------------------------------------------------
    // Input synchronizer
    // -----------------------------------------------------------------------
    logic [3:0] ja_s1_q;
    logic [3:0] ja_s2_q;
    logic [1:0] ab_sync;
    logic       btn_sync;
    logic       sw_sync;

    // Two-flop synchronizer for every JA bit.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge value of its neighbours; these synchronizer flops
    // carry no reset on purpose, they simply re-sample the pins every cycle.
    always_ff @(posedge clk) begin
        ja_s1_q <= JA;
        ja_s2_q <= ja_s1_q;
    end

    assign ab_sync  = ja_s2_q[1:0];
    assign btn_sync = ja_s2_q[2];
    assign sw_sync  = ja_s2_q[3];

    // -----------------------------------------------------------------------
    // A/B debounce: accept a new {B,A} after FILT identical samples
    // -----------------------------------------------------------------------
    logic [1:0] ab_cand_q;
    logic [1:0] ab_cand_d;
    logic [1:0] ab_filt_q;
    logic [1:0] ab_filt_d;
    logic [7:0] filt_cnt_q;
    logic [7:0] filt_cnt_d;
    logic [7:0] run_len;

    // Count how long the synchronized value has differed from the filtered one.
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ab_cand_d  = ab_sync;
        ab_filt_d  = ab_filt_q;
        filt_cnt_d = filt_cnt_q;
        run_len    = (ab_sync != ab_cand_q) ? 8'd1 : filt_cnt_q + 8'd1;
        if (ab_sync == ab_filt_q) begin
            filt_cnt_d = '0;
        end else if (run_len == FILT_C) begin
            ab_filt_d  = ab_sync;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = run_len;
        end
    end

    // Filter registers; reset adopts the current pin state so nothing is seen as a change.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_cand_q  <= ab_sync;
            ab_filt_q  <= ab_sync;
            filt_cnt_q <= '0;
        end else begin
            ab_cand_q  <= ab_cand_d;
            ab_filt_q  <= ab_filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Quadrature decode FSM
    // -----------------------------------------------------------------------
    qstate_e state_q;
    qstate_e state_d;
    logic    q_fwd;
    logic    q_bwd;
    logic    q_diag;

    // State register; reload from the pins on reset produces no step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= qstate_e'(ab_sync);
        end else begin
            state_q <= state_d;
        end
    end

    // Next state always follows the filtered input, including after an error.
    always_comb begin
        state_d = qstate_e'(ab_filt_q);
    end

    // Classify the transition from state_q to the filtered value.
    always_comb begin
        q_fwd  = 1'b0;
        q_bwd  = 1'b0;
        q_diag = 1'b0;
        unique case (state_q)
            S00: begin
                q_fwd  = (ab_filt_q == 2'b01);
                q_bwd  = (ab_filt_q == 2'b10);
                q_diag = (ab_filt_q == 2'b11);
            end
            S01: begin
                q_fwd  = (ab_filt_q == 2'b11);
                q_bwd  = (ab_filt_q == 2'b00);
                q_diag = (ab_filt_q == 2'b10);
            end
            S11: begin
                q_fwd  = (ab_filt_q == 2'b10);
                q_bwd  = (ab_filt_q == 2'b01);
                q_diag = (ab_filt_q == 2'b00);
            end
            S10: begin
                q_fwd  = (ab_filt_q == 2'b00);
                q_bwd  = (ab_filt_q == 2'b11);
                q_diag = (ab_filt_q == 2'b01);
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Configuration and status registers
    // -----------------------------------------------------------------------
    logic [2:0]          ctrl_q;
    logic signed [W-1:0] min_q;
    logic signed [W-1:0] max_q;
    logic signed [W-1:0] pos_q;
    logic signed [W-1:0] pos_d;
    logic                btn_prev_q;
    logic                btn_ev_q;
    logic                btn_ev_d;
    logic                err_q;
    logic                err_d;
    logic [7:0]          err_cnt_q;
    logic [7:0]          err_cnt_d;

    logic ctrl_en;
    logic ctrl_wrap;
    logic ctrl_x4;
    assign ctrl_en   = ctrl_q[0];
    assign ctrl_wrap = ctrl_q[1];
    assign ctrl_x4   = ctrl_q[2];

    logic wr_en;
    logic wr_pos;
    logic wr_ctrl;
    logic wr_min;
    logic wr_max;
    logic wr_status;
    assign wr_en     = cs & write;
    assign wr_pos    = wr_en && (addr == ADDR_POS);
    assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
    assign wr_min    = wr_en && (addr == ADDR_MIN);
    assign wr_max    = wr_en && (addr == ADDR_MAX);
    assign wr_status = wr_en && (addr == ADDR_STATUS);

    logic signed [W-1:0] wr_val;
    assign wr_val = wr_data[W-1:0];

    logic cfg_err;
    logic at_lim;
    assign cfg_err = (min_q > max_q);
    assign at_lim  = (pos_q == min_q) || (pos_q == max_q);

    // Steps: X4 counts every legal edge, otherwise only entries into S00.
    logic step_up;
    logic step_dn;
    assign step_up = ctrl_x4 ? q_fwd : (q_fwd && (state_q == S10));
    assign step_dn = ctrl_x4 ? q_bwd : (q_bwd && (state_q == S01));

    function automatic logic signed [W-1:0] clamp(
        input logic signed [W-1:0] v,
        input logic signed [W-1:0] lo,
        input logic signed [W-1:0] hi
    );
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // Position next value: bus write beats a step; an out-of-range position
    // is first clamped by the step without counting it.
    always_comb begin
        pos_d = pos_q;
        if (!cfg_err) begin
            if (wr_pos) begin
                pos_d = clamp(wr_val, min_q, max_q);
            end else if (ctrl_en && (step_up || step_dn)) begin
                if ((pos_q < min_q) || (pos_q > max_q)) begin
                    pos_d = clamp(pos_q, min_q, max_q);
                end else if (step_up) begin
                    if (pos_q == max_q) pos_d = ctrl_wrap ? min_q : max_q;
                    else                pos_d = pos_q + W'(1);
                end else begin
                    if (pos_q == min_q) pos_d = ctrl_wrap ? max_q : min_q;
                    else                pos_d = pos_q - W'(1);
                end
            end
        end
    end

    // Sticky event flags: a new event in the same cycle as its W1C wins.
    always_comb begin
        btn_ev_d  = btn_ev_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (wr_status && wr_data[0]) btn_ev_d = 1'b0;
        if (btn_sync && !btn_prev_q) btn_ev_d = 1'b1;
        if (wr_status && wr_data[1]) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
        if (q_diag) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_d == 8'hFF) ? 8'hFF : err_cnt_d + 8'd1;
        end
    end

    // Register bank and event state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            min_q      <= MIN_RESET;
            max_q      <= MAX_RESET;
            pos_q      <= '0;
            btn_prev_q <= btn_sync;
            btn_ev_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= wr_data[2:0];
            if (wr_min)  min_q  <= wr_val;
            if (wr_max)  max_q  <= wr_val;
            pos_q      <= pos_d;
            btn_prev_q <= btn_sync;
            btn_ev_q   <= btn_ev_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    logic [31:0] status_word;
    assign status_word = {16'd0, err_cnt_q, 3'd0, sw_sync, cfg_err, at_lim, err_q, btn_ev_q};

    // -----------------------------------------------------------------------
    // Optional interrupt
    // -----------------------------------------------------------------------
`ifdef ENC_IRQ_EN
    logic [2:0] irq_mask_q;
    logic       irq_q;
    logic       wr_irqm;
    assign wr_irqm = wr_en && (addr == ADDR_IRQM);

    // Mask register and registered interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_irqm) irq_mask_q <= wr_data[2:0];
            irq_q <= |(status_word[2:0] & irq_mask_q);
        end
    end

    assign irq = irq_q;
`endif

    // -----------------------------------------------------------------------
    // Read mux (non-destructive, independent of the read strobe)
    // -----------------------------------------------------------------------
    // Combinational read data selected by address; unmapped addresses read 0.
    always_comb begin
        rd_data = '0;
        unique case (addr)
            ADDR_POS:    rd_data = {{(32-W){pos_q[W-1]}}, pos_q};
            ADDR_CTRL:   rd_data = {29'd0, ctrl_q};
            ADDR_MIN:    rd_data = {{(32-W){min_q[W-1]}}, min_q};
            ADDR_MAX:    rd_data = {{(32-W){max_q[W-1]}}, max_q};
            ADDR_STATUS: rd_data = status_word;
`ifdef ENC_IRQ_EN
            ADDR_IRQM:   rd_data = {29'd0, irq_mask_q};
`endif
            default:     rd_data = '0;
        endcase
    end

    // Read strobe has no side effects and upper write bits are ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, read, wr_data[31:W]};

endmodule
